// File: rtl/ifetch_byte_assembler.sv
// Purpose : fetch front end; issues byte addresses to the memory controller and
//           assembles four little-endian bytes into a 32-bit instruction.
// Latency : inst_valid 5 edges after the first issue on a free bus; 1 edge on a cache hit.
// Backpressure: the word is held in HOLD until inst_ready; fetch_mem_rdy=0 stalls issue; rdy_in=0 freezes.
//
// Ports:
//   clk_in, rst_n_in           clock, asynchronous active-low reset
//   rdy_in                     global enable (0 = freeze, the in-flight byte is reissued later)
//   fetch_req_addr             byte address to memory (pc + issue_cnt, pc + 4 while holding)
//   fetch_mem_rdy, mem_byte    address accepted this cycle / data for last cycle's address
//   redirect_valid/_pc         flush and restart at {redirect_pc[31:2],2'b00}
//   inst_valid/_out/_pc/_ready instruction handshake to the decoder
//
// Optional build macro ICACHE_EN adds a direct-mapped one-word-per-line cache of
// ICACHE_LINES entries, looked up at the start of each instruction.

module ifetch_byte_assembler #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          ICACHE_LINES = 32
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    output logic [31:0] fetch_req_addr,
    input  logic        fetch_mem_rdy,
    input  logic [7:0]  mem_byte,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [2:0]  issue_cnt;   // bytes issued for the current word (0..4)
    logic [2:0]  recv_cnt;    // bytes received for the current word (0..4)
    logic        inflight;    // a byte for lane `slot` returns this cycle
    logic [1:0]  slot;
    logic [23:0] asm_bytes;   // lanes 0..2; lane 3 is merged straight into inst_out
    logic [31:0] full_word;
    logic        cache_hit;
    logic [31:0] hit_word;

    assign full_word = {mem_byte, asm_bytes};

    always_comb begin
        fetch_req_addr = pc + {29'd0, issue_cnt};
        if (state == HOLD) begin
            fetch_req_addr = pc + 32'd4;
        end
    end

`ifdef ICACHE_EN
    localparam int IDX_W = $clog2(ICACHE_LINES);
    localparam int TAG_W = 30 - IDX_W;

    logic [ICACHE_LINES-1:0] line_vld;
    logic [TAG_W-1:0]        line_tag  [ICACHE_LINES];
    logic [31:0]             line_word [ICACHE_LINES];
    logic [IDX_W-1:0]        idx;
    logic                    cache_fill;

    assign idx        = pc[IDX_W+1:2];
    // Only a lookup at the very start of a word may hit; inflight is always 0 there.
    assign cache_hit  = (state == FETCH) && (issue_cnt == 3'd0) && (recv_cnt == 3'd0) &&
                        line_vld[idx] && (line_tag[idx] == pc[31:IDX_W+2]);
    assign hit_word   = line_word[idx];
    assign cache_fill = rdy_in && !redirect_valid && (state == FETCH) && inflight && (slot == 2'd3);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            line_vld <= '0;
        end else if (cache_fill) begin
            line_vld[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (cache_fill) begin
            line_tag[idx]  <= pc[31:IDX_W+2];
            line_word[idx] <= full_word;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = (ICACHE_LINES > 1);
    assign cache_hit  = 1'b0;
    assign hit_word   = 32'd0;
`endif

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            issue_cnt  <= 3'd0;
            recv_cnt   <= 3'd0;
            inflight   <= 1'b0;
            slot       <= 2'd0;
            asm_bytes  <= 24'd0;
            inst_valid <= 1'b0;
            inst_out   <= 32'd0;
            inst_pc    <= 32'd0;
        end else if (redirect_valid) begin
            // Clearing inflight makes the byte returning next cycle be ignored.
            state      <= FETCH;
            pc         <= {redirect_pc[31:2], 2'b00};
            issue_cnt  <= 3'd0;
            recv_cnt   <= 3'd0;
            inflight   <= 1'b0;
            inst_valid <= 1'b0;
        end else if (!rdy_in) begin
            // The returning byte is dropped, so rewind issue to what was actually received.
            inflight  <= 1'b0;
            issue_cnt <= recv_cnt;
        end else begin
            case (state)
                FETCH: begin
                    inflight <= 1'b0;
                    if (cache_hit) begin
                        inst_out   <= hit_word;
                        inst_pc    <= pc;
                        inst_valid <= 1'b1;
                        state      <= HOLD;
                    end else begin
                        if ((issue_cnt != 3'd4) && fetch_mem_rdy) begin
                            issue_cnt <= issue_cnt + 3'd1;
                            inflight  <= 1'b1;
                            slot      <= issue_cnt[1:0];
                        end
                        // Data belongs to last cycle's accepted address, so it is
                        // captured regardless of this cycle's fetch_mem_rdy.
                        if (inflight) begin
                            recv_cnt <= recv_cnt + 3'd1;
                            case (slot)
                                2'd0: asm_bytes[7:0]   <= mem_byte;
                                2'd1: asm_bytes[15:8]  <= mem_byte;
                                2'd2: asm_bytes[23:16] <= mem_byte;
                                default: begin
                                    inst_out   <= full_word;
                                    inst_pc    <= pc;
                                    inst_valid <= 1'b1;
                                    state      <= HOLD;
                                end
                            endcase
                        end
                    end
                end
                HOLD: begin
                    inflight <= 1'b0;
                    if (inst_ready) begin
                        inst_valid <= 1'b0;
                        pc         <= pc + 32'd4;
                        issue_cnt  <= 3'd0;
                        recv_cnt   <= 3'd0;
                        state      <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_byte_assembler.sv
// Self-checking bench for ifetch_byte_assembler: directed steps from the test plan,
// then a randomized phase scored against an instruction-stream reference model
// (expected pc sequence plus little-endian words read from a byte memory).

module tb_ifetch_byte_assembler;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic [31:0] fetch_req_addr;
    logic        fetch_mem_rdy;
    logic [7:0]  mem_byte;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        inst_ready;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  mem [0:8191];
    logic        acc_q  = 1'b0;
    logic [31:0] addr_q = 32'd0;
    logic [7:0]  junk_q = 8'd0;

    ifetch_byte_assembler dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .rdy_in         (rdy_in),
        .fetch_req_addr (fetch_req_addr),
        .fetch_mem_rdy  (fetch_mem_rdy),
        .mem_byte       (mem_byte),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_out       (inst_out),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
    );

    always #5 clk_in = ~clk_in;

    // Memory controller: returns the byte for the address accepted one cycle earlier,
    // garbage when nothing was accepted.
    always @(posedge clk_in) begin
        acc_q  <= fetch_mem_rdy;
        addr_q <= fetch_req_addr;
        junk_q <= 8'($urandom);
    end
    assign mem_byte = acc_q ? mem[addr_q[12:0]] : junk_q;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [31:0] b;
        b = a;
        return {mem[13'(b + 32'd3)], mem[13'(b + 32'd2)], mem[13'(b + 32'd1)], mem[b[12:0]]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_n_in = 1'b0;
        #1;
        check("rst_async_valid", {31'd0, inst_valid}, 32'd0);
        rdy_in = 1'b1; fetch_mem_rdy = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 32'd0; inst_ready = 1'b0;
        tick(); tick();
        check("rst_out",  inst_out, 32'd0);
        check("rst_pc",   inst_pc, 32'd0);
        check("rst_addr", fetch_req_addr, 32'd0);
        rst_n_in = 1'b1;
    endtask

    // Counts edges from the current cycle until inst_valid is seen (bounded).
    task automatic wait_valid(output int n);
        n = 0;
        while (!inst_valid && n < 40) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int n_acc;
        logic [31:0] exp_pc;
        logic [31:0] prev_out, prev_pc;
        logic held, accept;

        for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'hA0; mem[3] = 8'h00;
        rst_n_in = 1'b0;
        do_reset();

        // Basic fetch: consecutive addresses, valid on the 5th edge.
        fetch_mem_rdy = 1'b1;
        check("t1_addr0", fetch_req_addr, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("t1_addr%0d", k), fetch_req_addr, 32'(k));
            check($sformatf("t1_novalid%0d", k), {31'd0, inst_valid}, 32'd0);
        end
        tick();
        check("t1_valid", {31'd0, inst_valid}, 32'd1);
        check("t1_word", inst_out, 32'h00A00513);
        check("t1_pc", inst_pc, 32'd0);

        // Backpressure: hold stable for 3 cycles, then accept.
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t2_hold_valid", {31'd0, inst_valid}, 32'd1);
            check("t2_hold_word", inst_out, 32'h00A00513);
            check("t2_hold_addr", fetch_req_addr, 32'd4);
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        check("t2_drop_valid", {31'd0, inst_valid}, 32'd0);
        check("t2_next_addr", fetch_req_addr, 32'd4);
        wait_valid(n);
        check("t2_lat", n, 32'd5);
        check("t2_pc", inst_pc, 32'd4);
        check("t2_word", inst_out, word_at(32'd4));

        // Memory stall after byte 1 issued.
        do_reset();
        fetch_mem_rdy = 1'b1;
        tick(); tick();
        fetch_mem_rdy = 1'b0;
        tick();
        check("t3_stall_addr_a", fetch_req_addr, 32'd2);
        tick();
        check("t3_stall_addr_b", fetch_req_addr, 32'd2);
        fetch_mem_rdy = 1'b1;
        wait_valid(n);
        check("t3_lat", 32'(4 + n), 32'd7);
        check("t3_word", inst_out, 32'h00A00513);

        // Redirect with byte 2 in flight.
        do_reset();
        fetch_mem_rdy = 1'b1;
        tick(); tick(); tick();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_1006;
        tick();
        redirect_valid = 1'b0;
        check("t4_valid_low", {31'd0, inst_valid}, 32'd0);
        check("t4_addr", fetch_req_addr, 32'h0000_1004);
        wait_valid(n);
        check("t4_lat", n, 32'd5);
        check("t4_pc", inst_pc, 32'h0000_1004);
        check("t4_word", inst_out, word_at(32'h0000_1004));

        // Freeze with byte 1 in flight: byte 1 reissued.
        do_reset();
        fetch_mem_rdy = 1'b1;
        tick(); tick();
        rdy_in = 1'b0;
        tick();
        check("t5_rewind_addr", fetch_req_addr, 32'd1);
        rdy_in = 1'b1;
        tick();
        check("t5_reissue_addr", fetch_req_addr, 32'd2);
        wait_valid(n);
        check("t5_lat", 32'(4 + n), 32'd7);
        check("t5_word", inst_out, 32'h00A00513);

`ifdef ICACHE_EN
        // Two-instruction loop, then an aliasing address evicting line 0.
        do_reset();
        fetch_mem_rdy = 1'b1; inst_ready = 1'b1;
        wait_valid(n);
        check("t6_miss0_lat", n, 32'd5);
        tick();
        wait_valid(n);
        check("t6_miss4_lat", n, 32'd5);
        check("t6_miss4_pc", inst_pc, 32'd4);
        redirect_valid = 1'b1; redirect_pc = 32'd0;
        tick();
        redirect_valid = 1'b0;
        tick();
        check("t6_hit0_valid", {31'd0, inst_valid}, 32'd1);
        check("t6_hit0_pc", inst_pc, 32'd0);
        check("t6_hit0_word", inst_out, word_at(32'd0));
        check("t6_hit0_addr", fetch_req_addr, 32'd4);
        tick();
        tick();
        check("t6_hit4_valid", {31'd0, inst_valid}, 32'd1);
        check("t6_hit4_word", inst_out, word_at(32'd4));
        redirect_valid = 1'b1; redirect_pc = 32'h80;
        tick();
        redirect_valid = 1'b0;
        wait_valid(n);
        check("t6_alias_lat", n, 32'd5);
        check("t6_alias_word", inst_out, word_at(32'h80));
        redirect_valid = 1'b1; redirect_pc = 32'd0;
        tick();
        redirect_valid = 1'b0;
        wait_valid(n);
        check("t6_refill_lat", n, 32'd5);
        check("t6_refill_word", inst_out, word_at(32'd0));
        inst_ready = 1'b0;
`endif

        // Randomized phase against the instruction-stream model.
        do_reset();
        exp_pc = 32'd0;
        n_acc = 0;
        for (int c = 0; c < 3000; c++) begin
            fetch_mem_rdy  = ($urandom_range(0, 3) != 0);
            inst_ready     = $urandom_range(0, 1) == 1;
            rdy_in         = ($urandom_range(0, 9) != 0);
            redirect_valid = rdy_in && ($urandom_range(0, 39) == 0);
            redirect_pc    = 32'($urandom_range(0, 127));
            accept = 1'b0;
            if (redirect_valid) begin
                exp_pc = {redirect_pc[31:2], 2'b00};
            end else if (rdy_in && inst_valid && inst_ready) begin
                accept = 1'b1;
                check("rand_pc", inst_pc, exp_pc);
                check("rand_word", inst_out, word_at(exp_pc));
                exp_pc = exp_pc + 32'd4;
                n_acc++;
            end
            held = inst_valid && !accept && !redirect_valid;
            prev_out = inst_out;
            prev_pc  = inst_pc;
            tick();
            if (held) begin
                check("rand_hold_valid", {31'd0, inst_valid}, 32'd1);
                check("rand_hold_word", inst_out, prev_out);
                check("rand_hold_pc", inst_pc, prev_pc);
            end
        end
        check("rand_progress", {31'd0, (n_acc >= 50)}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ifetch_byte_assembler.md
Name: ifetch_byte_assembler

Overview:
- Instruction fetch front end sitting directly upstream of the memory controller.
- Drives the fetch byte address into the controller and collects the byte-wide read data.
- Assembles four little-endian bytes into a 32-bit instruction and hands it to the decoder over a valid/ready handshake.
- Stalls while the LSB owns the memory bus and supports PC redirect (jump/branch flush).

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded at reset.
- ICACHE_LINES, 32, number of one-word direct-mapped cache lines; power of 2, >=2. Only used with ICACHE_EN.

Ports:
- clk_in  input  1  clock, all state updates on the rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- rdy_in  input  1  global enable; 0 = freeze.
- fetch_req_addr  output  32  byte address to the memory controller; equals pc + issue_cnt.
- fetch_mem_rdy  input  1  1 = this cycle's fetch address is accepted by the memory controller.
- mem_byte  input  8  read data for the address accepted in the previous cycle.
- redirect_valid  input  1  flush and restart fetch at redirect_pc.
- redirect_pc  input  32  new PC; bits [1:0] forced to 0.
- inst_valid  output  1  assembled instruction available.
- inst_out  output  32  instruction word.
- inst_pc  output  32  address of inst_out.
- inst_ready  input  1  decoder accepts the instruction this cycle.

Behaviour:
- Reset (rst_n_in=0, asynchronous):
  - pc=RESET_PC; issue_cnt=0; recv_cnt=0; inflight=0; state=FETCH.
  - inst_valid=0, inst_out=0, inst_pc=0.
  - Cache valid bits cleared.
  - Reset mid-assembly discards all partial bytes.
- States: FETCH (issuing/collecting bytes) and HOLD (instruction presented, waiting for inst_ready).
- Issue rule, FETCH with issue_cnt<4:
  - If fetch_mem_rdy=1: issue_cnt++ and inflight<=1 (slot = old issue_cnt).
  - Else: inflight<=0 and issue_cnt holds.
- Receive rule, inflight=1:
  - mem_byte is written into byte lane `slot` of the assembly register; recv_cnt++.
  - This happens even if fetch_mem_rdy=0 this cycle, since the controller muxes the address combinationally and the data belongs to the previous cycle's fetch address.
- Byte k lands in inst[8k+7:8k] (little-endian).
- Completion: when byte 3 is received, on that edge:
  - inst_out <= assembled word (with byte 3 merged); inst_pc <= pc; inst_valid <= 1; state <= HOLD.
- Latency: with the bus free, inst_valid rises on the 5th rising edge after the first issue.
- HOLD:
  - fetch_req_addr = pc + 4 (no issue; don't-care to the memory).
  - On inst_valid & inst_ready: inst_valid <= 0; pc <= pc+4; issue_cnt=recv_cnt=0; state <= FETCH.
  - pc wraps modulo 2^32.
- Redirect (highest priority, any state):
  - pc <= {redirect_pc[31:2],2'b00}; counters 0; inflight <= 0; inst_valid <= 0; state <= FETCH.
  - A byte returning in the next cycle is ignored.
  - A same-cycle inst_ready is ignored; pc comes from redirect_pc, not pc+4.
- rdy_in=0:
  - No state advances except: inflight <= 0 and issue_cnt <= recv_cnt, so the lost in-flight byte is reissued.
  - Outputs hold.
- fetch_mem_rdy held 0 indefinitely: fetch_req_addr stable, no progress, no deadlock once it returns to 1.

Optional Feature:
- Macro: ICACHE_EN.
- Defined:
  - Direct-mapped cache, ICACHE_LINES entries of {valid, tag = pc[31:2+log2(ICACHE_LINES)], 32-bit word}; index = pc[2+log2(ICACHE_LINES)-1:2].
  - Lookup in FETCH when issue_cnt=0 and recv_cnt=0. On a hit, no bytes are issued and the instruction is presented with inst_valid high on the next edge.
  - On every memory-assembled completion, the line is written (valid=1).
  - Redirect does not invalidate; reset clears all valid bits.
- Undefined: no cache storage; every instruction is fetched byte-wise; ICACHE_LINES is ignored.

Test Plan:
- Reset then release, fetch_mem_rdy=1, memory bytes at 0..3 = 13 05 A0 00 -> fetch_req_addr 0,1,2,3 on consecutive cycles; inst_valid rises 5 edges after the first issue with inst_out=32'h00A00513, inst_pc=0.
- Same, inst_ready held 0 for 3 cycles then 1 -> inst_valid/inst_out stable throughout; next cycle fetch_req_addr=4 and inst_pc of the next instruction = 4.
- fetch_mem_rdy=0 for 2 cycles after byte 1 is issued -> byte 1 still captured, fetch_req_addr held at pc+2 during the stall, final word correct, latency 7 edges.
- redirect_valid with redirect_pc=32'h0000_1006 while byte 2 is in flight -> inst_valid stays 0, next fetch_req_addr=32'h0000_1004, stale byte discarded, word at 0x1004 assembled.
- rdy_in=0 for one cycle while byte 1 is in flight -> byte 1 reissued at pc+1 after rdy_in returns; correct word.
- ICACHE_EN: execute a 2-instruction loop (redirect to 0 after pc 4) -> second pass produces inst_valid one edge after entry with no fetch issue cycles; pc=0x80 aliases index 0 with ICACHE_LINES=32 -> miss, refill.
